// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO controller for the MIPS multiply unit.
// Sequences an iterative unsigned multiplier through its start/ready handshake.
// Applies the signed-operand fix-up and owns the architectural HI/LO registers.
// Stalls the EX stage while a product is outstanding.
module muldiv_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_rs,
  input  logic [31:0] op_rt,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ready,
  input  logic [63:0] mul_product,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MFHI  = 3'b010;
  localparam logic [2:0] OP_MFLO  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIXUP = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic           neg_r;
  logic [63:0]    temp_r;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_inc_s;
  logic           timeout_s;
  logic [31:0]    hi_r;
  logic [31:0]    lo_r;
  logic [31:0]    mul_a_r;
  logic [31:0]    mul_b_r;
  logic           mul_err_r;
  logic           valid_op_s;
  logic           busy_s;
  logic           accept_s;
  logic           mult_acc_s;

  // Unsigned magnitude of a 32-bit two's complement value; 0x80000000 stays 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] x);
    logic [31:0] r;
    if (x[31]) begin
      r = ~x + 32'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Full 64-bit two's complement negation of the unsigned product.
  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Op decode: stall, accept and the combinational MFHI/MFLO read port.
  always_comb begin
    busy_s     = (state_r != IDLE);
    valid_op_s = op_valid & ~(op_code[2] & op_code[1]);
    // Reset forces the read port and stall low even with an op presented.
    accept_s   = valid_op_s & ~busy_s & rst_n;
    stall      = valid_op_s & busy_s & rst_n;
    mult_acc_s = accept_s & ((op_code == OP_MULT) | (op_code == OP_MULTU));
    rd_valid   = 1'b0;
    rd_data    = 32'd0;
    if (accept_s && (op_code == OP_MFHI)) begin
      rd_valid = 1'b1;
      rd_data  = hi_r;
    end else if (accept_s && (op_code == OP_MFLO)) begin
      rd_valid = 1'b1;
      rd_data  = lo_r;
    end else begin
      rd_valid = 1'b0;
      rd_data  = 32'd0;
    end
  end

  // Next-state logic; the watchdog aborts on the WAIT cycle the counter reaches TIMEOUT.
  always_comb begin
    state_next_s = state_r;
    cnt_inc_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (mult_acc_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = WAIT;
      end
      WAIT: begin
        if (mul_ready) begin
          state_next_s = FIXUP;
        end else if (cnt_inc_s == CW'(TIMEOUT)) begin
          timeout_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      FIXUP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, watchdog, product capture and HI/LO update per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_r     <= 1'b0;
      mul_a_r   <= 32'd0;
      mul_b_r   <= 32'd0;
      temp_r    <= 64'd0;
      cnt_r     <= {CW{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      mul_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mult_acc_s) begin
            neg_r   <= (op_code == OP_MULT) & (op_rs[31] ^ op_rt[31]);
            mul_a_r <= (op_code == OP_MULT) ? mag32(op_rs) : op_rs;
            mul_b_r <= (op_code == OP_MULT) ? mag32(op_rt) : op_rt;
          end else if (accept_s && (op_code == OP_MTHI)) begin
            hi_r <= op_rs;
          end else if (accept_s && (op_code == OP_MTLO)) begin
            lo_r <= op_rs;
          end else begin
            neg_r <= neg_r;
          end
        end
        ISSUE: begin
          cnt_r <= {CW{1'b0}};
        end
        WAIT: begin
          if (mul_ready) begin
            temp_r <= mul_product;
          end else begin
            cnt_r <= cnt_inc_s;
            if (timeout_s) begin
              mul_err_r <= 1'b1;
            end
          end
        end
        FIXUP: begin
          {hi_r, lo_r} <= neg_r ? neg64(temp_r) : temp_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy      = busy_s;
  assign mul_start = (state_r == ISSUE);
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign hi        = hi_r;
  assign lo        = lo_r;
  assign mul_err   = mul_err_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with a behavioural iterative multiplier.
module tb_muldiv_ctrl;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MFHI  = 3'b010;
  localparam logic [2:0] OP_MFLO  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_rs;
  logic [31:0] op_rt;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_ready;
  logic [63:0] mul_product;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] opq[$];
  logic [31:0] rdq[$];

  int          m_lat = 3;
  logic        m_pend;
  int          m_cnt;
  logic [63:0] m_prod;

  muldiv_ctrl #(.TIMEOUT(40)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_rs(op_rs), .op_rt(op_rt), .stall(stall), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_ready(mul_ready), .mul_product(mul_product),
    .hi(hi), .lo(lo), .mul_err(mul_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Multiplier model: latency m_lat cycles after mul_start; m_lat=0 never answers.
  initial begin
    mul_ready = 1'b0;
    mul_product = 64'd0;
    m_pend = 1'b0;
    m_cnt = 0;
    m_prod = 64'd0;
    forever begin
      @(negedge clk);
      mul_ready = 1'b0;
      if (!rst_n) begin
        m_pend = 1'b0;
      end else if (mul_start) begin
        m_pend = 1'b1;
        m_cnt  = m_lat;
        m_prod = {32'd0, mul_a} * {32'd0, mul_b};
      end else if (m_pend && m_lat != 0) begin
        if (m_cnt <= 1) begin
          mul_ready   = 1'b1;
          mul_product = m_prod;
          m_pend      = 1'b0;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  end

  // Monitor: compares operands at each start pulse and read data on each rd_valid.
  initial begin
    logic        prev_start;
    logic [63:0] e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        chk("start_one_cycle", {63'd0, prev_start}, 64'd0);
        if (opq.size() == 0) begin
          checks++; errors++;
          $display("FAIL operands_unexpected actual=0x%0h_%0h required=none", mul_a, mul_b);
        end else begin
          e = opq.pop_front();
          chk("mul_operands", {mul_a, mul_b}, e);
        end
      end
      if (rd_valid) begin
        if (rdq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual=0x%0h required=none", rd_data);
        end else begin
          e = {32'd0, rdq.pop_front()};
          chk("rd_data", {32'd0, rd_data}, e);
        end
      end
      prev_start = mul_start;
    end
  end

  // Present one op from posedge+1, hold until accepted, return at posedge+1.
  task automatic do_op(input logic [2:0] code, input logic [31:0] rs,
                       input logic [31:0] rt, output int stalls);
    op_valid = 1'b1; op_code = code; op_rs = rs; op_rt = rt;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    chk("stall_bound", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = OP_NOP;
  endtask

  task automatic mult_case(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] a_exp, input logic [31:0] b_exp,
                           input logic [31:0] hi_exp, input logic [31:0] lo_exp, input int lat);
    int s;
    m_lat = lat;
    opq.push_back({a_exp, b_exp});
    do_op(code, rs, rt, s);
    rdq.push_back(hi_exp);
    do_op(OP_MFHI, 32'd0, 32'd0, s);
    rdq.push_back(lo_exp);
    do_op(OP_MFLO, 32'd0, 32'd0, s);
    chk("hi_reg", {32'd0, hi}, {32'd0, hi_exp});
    chk("lo_reg", {32'd0, lo}, {32'd0, lo_exp});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      {63'd0, busy}, 64'd0);
    chk({tag, "_mul_start"}, {63'd0, mul_start}, 64'd0);
    chk({tag, "_stall"},     {63'd0, stall}, 64'd0);
    chk({tag, "_rd_valid"},  {63'd0, rd_valid}, 64'd0);
    chk({tag, "_rd_data"},   {32'd0, rd_data}, 64'd0);
    chk({tag, "_mul_ab"},    {mul_a, mul_b}, 64'd0);
    chk({tag, "_hilo"},      {hi, lo}, 64'd0);
    chk({tag, "_mul_err"},   {63'd0, mul_err}, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int s;
    int n;
    rst_n = 1'b0; op_valid = 1'b0; op_code = OP_NOP; op_rs = 32'd0; op_rt = 32'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed, unsigned and most-negative operand products.
    mult_case(OP_MULT,  32'd100, 32'hFFFFFFFD, 32'd100, 32'd3, 32'hFFFFFFFF, 32'hFFFFFED4, 3);
    mult_case(OP_MULTU, 32'hFFFFFFFD, 32'd100, 32'hFFFFFFFD, 32'd100, 32'h00000063, 32'hFFFFFED4, 4);
    mult_case(OP_MULT,  32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 2);
    mult_case(OP_MULT,  32'hFFFFFFF9, 32'hFFFFFFFA, 32'd7, 32'd6, 32'd0, 32'd42, 1);

    // MULT 7*6 then MFLO next cycle: stalls ISSUE + 3 WAIT + FIXUP = 5 cycles.
    m_lat = 3;
    opq.push_back({32'd7, 32'd6});
    do_op(OP_MULT, 32'd7, 32'd6, s);
    rdq.push_back(32'd42);
    do_op(OP_MFLO, 32'd0, 32'd0, s);
    chk("mflo_stall_cycles", 64'(s), 64'd5);

    // MTHI/MTLO are single-cycle and never stall from idle.
    do_op(OP_MTHI, 32'h12345678, 32'd0, s);
    chk("mthi_stall", 64'(s), 64'd0);
    rdq.push_back(32'h12345678);
    do_op(OP_MFHI, 32'd0, 32'd0, s);
    chk("mfhi_stall", 64'(s), 64'd0);
    do_op(OP_MTLO, 32'hCAFEF00D, 32'd0, s);
    rdq.push_back(32'hCAFEF00D);
    do_op(OP_MFLO, 32'd0, 32'd0, s);
    chk("mflo_after_mtlo_stall", 64'(s), 64'd0);

    // Watchdog: no ready; busy for ISSUE + 40 WAIT cycles, no-op never stalls.
    m_lat = 0;
    opq.push_back({32'd5, 32'd5});
    do_op(OP_MULT, 32'd5, 32'd5, s);
    op_valid = 1'b1; op_code = OP_NOP;
    n = 0;
    @(negedge clk);
    chk("nop_no_stall", {63'd0, stall}, 64'd0);
    chk("nop_busy", {63'd0, busy}, 64'd1);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("timeout_busy_cycles", 64'(n), 64'd41);
    chk("timeout_mul_err", {63'd0, mul_err}, 64'd1);
    chk("timeout_hilo", {hi, lo}, {32'h12345678, 32'hCAFEF00D});
    @(posedge clk); #1;
    rdq.push_back(32'h12345678);
    do_op(OP_MFHI, 32'd0, 32'd0, s);

    // Reset during WAIT with a stalled MFHI presented.
    m_lat = 10;
    opq.push_back({32'd9, 32'd9});
    do_op(OP_MULT, 32'd9, 32'd9, s);
    op_valid = 1'b1; op_code = OP_MFHI;
    repeat (2) @(negedge clk);
    chk("wait_stall", {63'd0, stall}, 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    op_valid = 1'b0; op_code = OP_NOP;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    mult_case(OP_MULT, 32'd2, 32'd3, 32'd2, 32'd3, 32'd0, 32'd6, 2);

    repeat (3) @(negedge clk);
    chk("opq_drained", 64'(opq.size()), 64'd0);
    chk("rdq_drained", 64'(rdq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
